sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
Arbitrates one single-port synchronous SRAM between two requesters: the instruction-fetch port (pc/if_id) and the data port (mem stage). Cores built on a unified memory use it in place of separate instruction and data SRAMs. Per-cycle req/gnt handshake with a one-cycle read response. Denied requesters drive stalls back into the pipeline.

Parameters:
ADDR_W, 32, address width of both ports and the SRAM
DATA_W, 32, data width
STARVE_MAX, 4, consecutive denied if_req cycles after which IF wins the next contention; 0 = strict data priority

Ports:
soc_clk  in  1  clock; all state on rising edge
resetn  in  1  asynchronous active-low reset
if_req  in  1  fetch request this cycle
if_addr  in  ADDR_W  fetch address
if_flush  in  1  drop the IF response returning this cycle (branch redirect)
if_gnt  out  1  fetch accepted this cycle
if_rdata  out  DATA_W  fetch data
if_valid  out  1  fetch data valid (1-cycle pulse)
d_req  in  1  data request this cycle
d_we  in  1  1 = write, 0 = read
d_wen  in  4  byte write enables
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_gnt  out  1  data request accepted this cycle
d_rdata  out  DATA_W  load data
d_valid  out  1  data response (read data or write ack)
sram_en  out  1  SRAM enable
sram_wen  out  4  SRAM byte write enables
sram_addr  out  ADDR_W  SRAM address
sram_wdata  out  DATA_W  SRAM write data
sram_rdata  in  DATA_W  SRAM read data, valid one cycle after enable

Behaviour:
- Grant (combinational): one grant per cycle at most. Only one req high: it is granted. Both high: d_gnt wins unless starve_cnt == STARVE_MAX and STARVE_MAX != 0, then if_gnt wins.
- Requester treats req&~gnt as stall and holds req/addr/data stable until granted. req&gnt = accepted; the next request may follow in the next cycle (back-to-back, full throughput).
- starve_cnt: clears when if_req=0 or if_gnt=1. Increments when if_req&~if_gnt. Saturates at STARVE_MAX.
- SRAM drive: sram_en = if_gnt|d_gnt. sram_addr = d_gnt ? d_addr : if_addr.
- SRAM writes: sram_wen = (d_gnt&d_we) ? d_wen : 4'b0. sram_wdata = d_wdata.
- Addresses pass through unmodified; alignment is the requester's responsibility.
- Response: owner register (NONE/IF/D) and a we flag are loaded from the grant in cycle N.
- Cycle N+1, owner IF: if_valid=~if_flush, if_rdata=sram_rdata.
- Cycle N+1, owner D read: d_valid=1, d_rdata=sram_rdata.
- Cycle N+1, owner D write: d_valid=1, d_rdata = held value.
- Hold registers: if_hold/d_hold capture sram_rdata on each read valid. When valid=0, rdata outputs show the hold value, so data survives a stalled consumer.
- if_flush affects only the response cycle. It does not block a new if_gnt in the same cycle. A flush when owner!=IF has no effect.
- Reset (async, any time): owner=NONE, starve_cnt=0, holds=0, valids=0.
- While resetn=0: gnts, sram_en and sram_wen forced 0. An outstanding response is discarded and no valid is ever produced for it.
- Response outputs (owner, valids) are registered; no combinational path from req to valid.

Test Plan:
- IF only: if_req=1, if_addr=0x00000000..0x0C over 4 cycles. Expect if_gnt=1 every cycle, if_valid one cycle later each, if_rdata = preloaded words in order, d_gnt=0.
- Contention: both req high, d read 0x100 (mem=0xDEADBEEF). Expect d_gnt=1, if_gnt=0 in cycle N. Cycle N+1: d_valid=1, d_rdata=0xDEADBEEF. if_gnt=1 in N+1 once d_req drops.
- Starvation, STARVE_MAX=4: d_req and if_req held high 10 cycles. Expect if_gnt=1 in the 5th cycle, starve_cnt back to 0, then data wins 4 cycles, IF wins again.
- Write: d_we=1, d_wen=4'b0011, d_addr=0x200, d_wdata=0x12345678 over 0xFFFFFFFF. Expect sram_wen=0011, d_valid next cycle; a following read returns 0xFFFF5678; d_rdata keeps previous hold during the write ack.
- Flush: if granted in N, if_flush=1 in N+1. Expect if_valid=0, if_hold unchanged. A new if_req in N+1 is granted and returns valid in N+2.
- Reset mid-read: resetn low in N+1 after a d read grant. Expect d_valid=0, outputs zero, d_rdata=0. After release, the first grant behaves normally.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// Bundle between the arbiter, its two requesters and the shared SRAM macro.
// The master side is the environment, i.e. the requesters plus the SRAM read port.
interface sram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;

  logic              d_req;
  logic              d_we;
  logic [3:0]        d_wen;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;

  logic              sram_en;
  logic [3:0]        sram_wen;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  modport master (
    output if_req, if_addr, if_flush,
    output d_req, d_we, d_wen, d_addr, d_wdata,
    output sram_rdata,
    input  if_gnt, if_rdata, if_valid,
    input  d_gnt, d_rdata, d_valid,
    input  sram_en, sram_wen, sram_addr, sram_wdata
  );

  modport slave (
    input  if_req, if_addr, if_flush,
    input  d_req, d_we, d_wen, d_addr, d_wdata,
    input  sram_rdata,
    output if_gnt, if_rdata, if_valid,
    output d_gnt, d_rdata, d_valid,
    output sram_en, sram_wen, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Shares one single-port synchronous SRAM between instruction fetch and the data port.
// Data wins contention unless IF has been starved for STARVE_MAX consecutive cycles.
module sram_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic          soc_clk,
  input logic          resetn,
  sram_arbiter_if.slave bus
);

  localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  owner_t            owner, owner_nxt;
  logic              we_q, we_nxt;
  logic [CNT_W-1:0]  starve_cnt, starve_cnt_nxt;
  logic [DATA_W-1:0] if_hold, if_hold_nxt;
  logic [DATA_W-1:0] d_hold, d_hold_nxt;

  logic starve_hit;
  logic if_gnt, d_gnt;
  logic if_valid, d_valid, d_rd_valid;

  // Grants are gated by resetn so nothing reaches the SRAM while reset is held.
  always_comb begin
    starve_hit = (STARVE_MAX != 0) && (starve_cnt == STARVE_LIM);
    d_gnt      = resetn && bus.d_req && !(bus.if_req && starve_hit);
    if_gnt     = resetn && bus.if_req && !d_gnt;
  end

  always_comb begin
    owner_nxt      = OWN_NONE;
    we_nxt         = 1'b0;
    starve_cnt_nxt = starve_cnt;
    if (d_gnt) begin
      owner_nxt = OWN_D;
      we_nxt    = bus.d_we;
    end else if (if_gnt) begin
      owner_nxt = OWN_IF;
    end

    if (!bus.if_req || if_gnt)
      starve_cnt_nxt = '0;
    else if (starve_cnt != STARVE_LIM)
      starve_cnt_nxt = starve_cnt + 1'b1;

    // Flush only masks the IF response; a data response is never affected.
    if_valid    = (owner == OWN_IF) && !bus.if_flush;
    d_valid     = (owner == OWN_D);
    d_rd_valid  = d_valid && !we_q;
    if_hold_nxt = if_valid   ? bus.sram_rdata : if_hold;
    d_hold_nxt  = d_rd_valid ? bus.sram_rdata : d_hold;
  end

  always_ff @(posedge soc_clk or negedge resetn) begin
    if (!resetn) begin
      owner      <= OWN_NONE;
      we_q       <= 1'b0;
      starve_cnt <= '0;
      if_hold    <= '0;
      d_hold     <= '0;
    end else begin
      owner      <= owner_nxt;
      we_q       <= we_nxt;
      starve_cnt <= starve_cnt_nxt;
      if_hold    <= if_hold_nxt;
      d_hold     <= d_hold_nxt;
    end
  end

  assign bus.if_gnt     = if_gnt;
  assign bus.d_gnt      = d_gnt;
  assign bus.if_valid   = if_valid;
  assign bus.d_valid    = d_valid;
  assign bus.if_rdata   = if_valid   ? bus.sram_rdata : if_hold;
  assign bus.d_rdata    = d_rd_valid ? bus.sram_rdata : d_hold;
  assign bus.sram_en    = if_gnt | d_gnt;
  assign bus.sram_addr  = d_gnt ? bus.d_addr : bus.if_addr;
  assign bus.sram_wen   = (d_gnt && bus.d_we) ? bus.d_wen : 4'b0000;
  assign bus.sram_wdata = bus.d_wdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural byte-writable SRAM model.
module tb_sram_arbiter;

  logic soc_clk = 1'b0;
  logic resetn  = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [31:0] mem [0:1023];

  sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  sram_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .soc_clk (soc_clk),
    .resetn  (resetn),
    .bus     (bus.slave)
  );

  always #5 soc_clk = ~soc_clk;

  always @(posedge soc_clk) begin
    if (bus.sram_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.sram_wen[b]) mem[bus.sram_addr[11:2]][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
      bus.sram_rdata <= mem[bus.sram_addr[11:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the rising edge; inputs are driven here, checks follow a #1 settle.
  task automatic next_cycle();
    @(posedge soc_clk);
    #1;
  endtask

  task automatic idle();
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_wen = 4'b0000;
    bus.d_addr = '0; bus.d_wdata = '0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    for (int i = 0; i < 5; i++) mem[i] = 32'h1111_0000 + i;
    mem[32'h100 >> 2] = 32'hDEAD_BEEF;
    mem[32'h200 >> 2] = 32'hFFFF_FFFF;
    bus.sram_rdata = '0;
    idle();

    // Reset: requests present but everything toward the SRAM stays quiet
    bus.if_req = 1'b1; bus.d_req = 1'b1; bus.d_addr = 32'h100;
    #2;
    check("rst_if_gnt",   32'(bus.if_gnt),   32'h0);
    check("rst_d_gnt",    32'(bus.d_gnt),    32'h0);
    check("rst_sram_en",  32'(bus.sram_en),  32'h0);
    check("rst_if_valid", 32'(bus.if_valid), 32'h0);
    check("rst_d_valid",  32'(bus.d_valid),  32'h0);
    check("rst_if_rdata", bus.if_rdata,      32'h0);
    check("rst_d_rdata",  bus.d_rdata,       32'h0);
    next_cycle();
    idle();
    next_cycle();
    resetn = 1'b1;

    // IF only, 4 back-to-back fetches
    for (int i = 0; i < 4; i++) begin
      if (i > 0) next_cycle();
      bus.if_req = 1'b1; bus.if_addr = 32'(4 * i);
      #1;
      check("if_only_gnt",   32'(bus.if_gnt), 32'h1);
      check("if_only_d_gnt", 32'(bus.d_gnt),  32'h0);
      check("if_only_addr",  bus.sram_addr,   32'(4 * i));
      if (i > 0) begin
        check("if_only_valid", 32'(bus.if_valid), 32'h1);
        check("if_only_rdata", bus.if_rdata,      32'h1111_0000 + 32'(i - 1));
      end
    end
    next_cycle();
    idle();
    #1;
    check("if_only_last_valid", 32'(bus.if_valid), 32'h1);
    check("if_only_last_rdata", bus.if_rdata,      32'h1111_0003);
    check("if_only_gnt_drop",   32'(bus.if_gnt),   32'h0);

    // Contention: data read wins, IF follows once d_req drops
    next_cycle();
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
    #1;
    check("cont_d_gnt",  32'(bus.d_gnt),  32'h1);
    check("cont_if_gnt", 32'(bus.if_gnt), 32'h0);
    check("cont_addr",   bus.sram_addr,   32'h100);
    check("cont_wen",    32'(bus.sram_wen), 32'h0);
    next_cycle();
    bus.d_req = 1'b0;
    #1;
    check("cont_d_valid",  32'(bus.d_valid), 32'h1);
    check("cont_d_rdata",  bus.d_rdata,      32'hDEAD_BEEF);
    check("cont_if_gnt2",  32'(bus.if_gnt),  32'h1);
    check("cont_if_valid", 32'(bus.if_valid), 32'h0);
    next_cycle();
    idle();
    #1;
    check("cont_if_valid2", 32'(bus.if_valid), 32'h1);
    check("cont_if_rdata",  bus.if_rdata,      32'h1111_0004);
    check("cont_d_hold",    bus.d_rdata,       32'hDEAD_BEEF);
    check("cont_d_valid2",  32'(bus.d_valid),  32'h0);

    // Starvation: IF wins on the 5th and 10th contended cycle
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      bus.if_req = 1'b1; bus.if_addr = 32'h0;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
      #1;
      check($sformatf("starve_if_gnt_c%0d", c), 32'(bus.if_gnt), (c == 5 || c == 10) ? 32'h1 : 32'h0);
      check($sformatf("starve_d_gnt_c%0d", c),  32'(bus.d_gnt),  (c == 5 || c == 10) ? 32'h0 : 32'h1);
      if (c == 6) check("starve_if_valid_c6", 32'(bus.if_valid), 32'h1);
    end
    next_cycle();
    idle();
    #1;
    check("starve_tail_if_valid", 32'(bus.if_valid), 32'h1);
    check("starve_tail_if_rdata", bus.if_rdata,      32'h1111_0000);

    // Partial write, then read back the merged word
    next_cycle();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_wen = 4'b0011;
    bus.d_addr = 32'h200; bus.d_wdata = 32'h1234_5678;
    #1;
    check("wr_d_gnt", 32'(bus.d_gnt),  32'h1);
    check("wr_wen",   32'(bus.sram_wen), 32'h3);
    check("wr_wdata", bus.sram_wdata,  32'h1234_5678);
    check("wr_addr",  bus.sram_addr,   32'h200);
    next_cycle();
    bus.d_we = 1'b0; bus.d_wen = 4'b0000;
    #1;
    check("wr_ack_valid", 32'(bus.d_valid), 32'h1);
    check("wr_ack_rdata", bus.d_rdata,      32'hDEAD_BEEF);
    check("rd_wen",       32'(bus.sram_wen), 32'h0);
    next_cycle();
    idle();
    #1;
    check("rd_back_valid", 32'(bus.d_valid), 32'h1);
    check("rd_back_rdata", bus.d_rdata,      32'hFFFF_5678);
    next_cycle();
    #1;
    check("rd_hold_valid", 32'(bus.d_valid), 32'h0);
    check("rd_hold_rdata", bus.d_rdata,      32'hFFFF_5678);

    // Flush drops the response but not a new grant in the same cycle
    next_cycle();
    bus.if_req = 1'b1; bus.if_addr = 32'h8;
    #1;
    check("fl_gnt", 32'(bus.if_gnt), 32'h1);
    next_cycle();
    bus.if_addr = 32'hC; bus.if_flush = 1'b1;
    #1;
    check("fl_valid", 32'(bus.if_valid), 32'h0);
    check("fl_hold",  bus.if_rdata,      32'h1111_0000);
    check("fl_gnt2",  32'(bus.if_gnt),   32'h1);
    next_cycle();
    idle();
    #1;
    check("fl_new_valid", 32'(bus.if_valid), 32'h1);
    check("fl_new_rdata", bus.if_rdata,      32'h1111_0003);

    // Flush while data owns the response has no effect
    next_cycle();
    bus.d_req = 1'b1; bus.d_addr = 32'h100;
    next_cycle();
    bus.d_req = 1'b0; bus.if_flush = 1'b1;
    #1;
    check("fl_d_valid", 32'(bus.d_valid), 32'h1);
    check("fl_d_rdata", bus.d_rdata,      32'hDEAD_BEEF);
    next_cycle();
    idle();

    // Reset in the response cycle of a data read
    next_cycle();
    bus.d_req = 1'b1; bus.d_addr = 32'h200;
    #1;
    check("mr_gnt", 32'(bus.d_gnt), 32'h1);
    next_cycle();
    resetn = 1'b0;
    #1;
    check("mr_d_valid",  32'(bus.d_valid),  32'h0);
    check("mr_d_rdata",  bus.d_rdata,       32'h0);
    check("mr_if_rdata", bus.if_rdata,      32'h0);
    check("mr_d_gnt",    32'(bus.d_gnt),    32'h0);
    check("mr_sram_en",  32'(bus.sram_en),  32'h0);
    check("mr_sram_wen", 32'(bus.sram_wen), 32'h0);
    next_cycle();
    #1;
    check("mr_no_stale_valid", 32'(bus.d_valid), 32'h0);
    resetn = 1'b1;
    bus.d_addr = 32'h100;
    #1;
    check("mr_post_gnt",   32'(bus.d_gnt),   32'h1);
    check("mr_post_valid", 32'(bus.d_valid), 32'h0);
    next_cycle();
    idle();
    #1;
    check("mr_post_rvalid", 32'(bus.d_valid), 32'h1);
    check("mr_post_rdata",  bus.d_rdata,      32'hDEAD_BEEF);

    next_cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
